// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers for the key schedule.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } ks_state_t;

  localparam int         NUM_ROUNDS = 10;
  localparam logic [7:0] RCON_INIT  = 8'h01;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

  // x^254 is the inverse for nonzero x and maps 0 to 0, as AES requires.
  assign x2   = gf_mul(a, a);
  assign x3   = gf_mul(x2, a);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign inv  = gf_mul(gf_mul(x240, x12), x2);

  assign s = inv
           ^ {inv[6:0], inv[7]}
           ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]}
           ^ 8'h63;

endmodule

// File: rtl/key_step.sv
// One combinational AES-128 key-expansion round: (prev_key, rcon) -> next_key.
module key_step
  import aes_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  word_t w0, w1, w2, w3;
  word_t rot, sub;
  word_t n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prev_key;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sub
    aes_sbox u_sbox (
      .a (rot[8*gi +: 8]),
      .s (sub[8*gi +: 8])
    );
  end

  assign n0 = w0 ^ sub ^ {rcon, 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule sequencer: captures a key, then emits round keys 0..10
// over a valid/ready handshake and pulses done after the last one is taken.
module key_schedule_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round,
  output logic         busy,
  output logic         done
);

  ks_state_t   state_reg, state_next;
  block_t      key_reg, key_next;
  logic [3:0]  round_reg, round_next;
  logic [7:0]  rcon_reg, rcon_next;
  logic        done_reg, done_next;
  block_t      stepped_key;
  logic        fire;

  key_step u_key_step (
    .prev_key (key_reg),
    .rcon     (rcon_reg),
    .next_key (stepped_key)
  );

  assign fire = (state_reg == EMIT) && rk_ready;

  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    round_next = round_reg;
    rcon_next  = rcon_reg;
    done_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          key_next   = key;
          round_next = 4'd0;
          rcon_next  = RCON_INIT;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (fire) begin
          if (round_reg == 4'(NUM_ROUNDS)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            key_next   = stepped_key;
            round_next = round_reg + 4'd1;
            rcon_next  = xtime(rcon_reg);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      round_reg <= 4'd0;
      rcon_reg  <= RCON_INIT;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      round_reg <= round_next;
      rcon_reg  <= rcon_next;
      done_reg  <= done_next;
    end
  end

  // Valid and busy decode straight from the state register, so no input reaches them.
  assign rk_valid  = (state_reg == EMIT);
  assign busy      = (state_reg == EMIT);
  assign round_key = key_reg;
  assign round     = round_reg;
  assign done      = done_reg;

endmodule
